// File: rtl/debounce_edge_if.sv
// Event handshake between the debouncer and its consumer: a single-entry
// valid/ready event slot plus the sticky overflow flag and its clear.
interface debounce_edge_if #(
    parameter int unsigned WIDTH = 6
);
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_data;
    logic [WIDTH-1:0] evt_mask;
    logic             evt_overflow;
    logic             clr_ovf;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_mask,
        output evt_overflow,
        input  evt_ready,
        input  clr_ovf
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_mask,
        input  evt_overflow,
        output evt_ready,
        output clr_ovf
    );
endinterface

// File: rtl/debounce_edge.sv
// Per-bit debouncer with registered rise/fall pulses and a single-entry
// change-event buffer (sticky overflow when an event arrives while full).
module debounce_edge #(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inD,
    output logic [WIDTH-1:0] outD,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    debounce_edge_if.master  evt
);
    localparam int unsigned   CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cntNext [WIDTH];
    logic [WIDTH-1:0] outNext;
    logic [WIDTH-1:0] chg;
    logic             evFree;
    logic             anyChg;

    // A differing sample that completes the run updates the level and
    // restarts the counter; any matching sample restarts it as well.
    always_comb begin
        outNext = outD;
        chg     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cntNext[i] = '0;
            if (inD[i] != outD[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    outNext[i] = inD[i];
                    chg[i]     = 1'b1;
                end else begin
                    cntNext[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        evFree = !evt.evt_valid || evt.evt_ready;
        anyChg = |chg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            outD             <= '0;
            rise             <= '0;
            fall             <= '0;
            evt.evt_valid    <= 1'b0;
            evt.evt_data     <= '0;
            evt.evt_mask     <= '0;
            evt.evt_overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cntNext[i];
            end
            outD <= outNext;
            rise <= chg & outNext;
            fall <= chg & ~outNext;

            // Transfer and new change on one edge reload the slot with no gap.
            if (anyChg && evFree) begin
                evt.evt_valid <= 1'b1;
                evt.evt_data  <= outNext;
                evt.evt_mask  <= chg;
            end else if (evt.evt_valid && evt.evt_ready) begin
                evt.evt_valid <= 1'b0;
            end

            // A drop on the same edge as a clear leaves the flag set.
            if (anyChg && !evFree) begin
                evt.evt_overflow <= 1'b1;
            end else if (evt.clr_ovf) begin
                evt.evt_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: a vector table for the 4-cycle build plus
// hand sequences for mid-count reset and the 1-cycle build.
module tb_debounce_edge;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] inA, outA, riseA, fallA;
    logic [5:0] inB, outB, riseB, fallB;

    int checks   = 0;
    int failures = 0;

    debounce_edge_if #(.WIDTH(6)) evtA ();
    debounce_edge_if #(.WIDTH(6)) evtB ();

    debounce_edge #(.WIDTH(6), .STABLE_CYCLES(4)) dutA (
        .clk(clk), .rst_n(rst_n), .inD(inA),
        .outD(outA), .rise(riseA), .fall(fallA), .evt(evtA)
    );

    debounce_edge #(.WIDTH(6), .STABLE_CYCLES(1)) dutB (
        .clk(clk), .rst_n(rst_n), .inD(inB),
        .outD(outB), .rise(riseB), .fall(fallB), .evt(evtB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstN;
        logic [5:0] in;
        logic       rdy;
        logic       clr;
        logic [5:0] expOut;
        logic [5:0] expRise;
        logic [5:0] expFall;
        logic       expValid;
        logic [5:0] expData;
        logic [5:0] expMask;
        logic       expOvf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic edgeA(input logic r, input logic [5:0] i, input logic rdy, input logic clr);
        rst_n = r;
        inA = i;
        evtA.evt_ready = rdy;
        evtA.clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [5:0] i, input logic rdy, input logic clr,
                       input logic [5:0] o, input logic [5:0] rs, input logic [5:0] fl,
                       input logic v, input logic [5:0] d, input logic [5:0] m, input logic f);
        vec_t x;
        x.rstN = r; x.in = i; x.rdy = rdy; x.clr = clr;
        x.expOut = o; x.expRise = rs; x.expFall = fl;
        x.expValid = v; x.expData = d; x.expMask = m; x.expOvf = f;
        vecs.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0;
        inA = '0; inB = '0;
        evtA.evt_ready = 1'b0; evtA.clr_ovf = 1'b0;
        evtB.evt_ready = 1'b1; evtB.clr_ovf = 1'b0;

        // reset with 110011 held on the input
        add(0, 6'h33, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h00, 0);
        add(0, 6'h33, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h00, 0);
        for (int k = 0; k < 3; k++)
            add(1, 6'h33, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h00, 0);
        add(1, 6'h33, 0, 0, 6'h33, 6'h33, 6'h00, 1, 6'h33, 6'h33, 0);
        add(1, 6'h33, 1, 0, 6'h33, 6'h00, 6'h00, 0, 6'h33, 6'h33, 0);
        // back to zero: multi-bit fall
        for (int k = 0; k < 3; k++)
            add(1, 6'h00, 1, 0, 6'h33, 6'h00, 6'h00, 0, 6'h33, 6'h33, 0);
        add(1, 6'h00, 1, 0, 6'h00, 6'h00, 6'h33, 1, 6'h00, 6'h33, 0);
        add(1, 6'h00, 1, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h33, 0);
        // 3-sample glitch on bit 0 is rejected
        for (int k = 0; k < 3; k++)
            add(1, 6'h01, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h33, 0);
        add(1, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h33, 0);
        add(1, 6'h00, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h33, 0);
        // backpressure: first accepted, second dropped
        for (int k = 0; k < 3; k++)
            add(1, 6'h01, 0, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h33, 0);
        add(1, 6'h01, 0, 0, 6'h01, 6'h01, 6'h00, 1, 6'h01, 6'h01, 0);
        for (int k = 0; k < 3; k++)
            add(1, 6'h03, 0, 0, 6'h01, 6'h00, 6'h00, 1, 6'h01, 6'h01, 0);
        add(1, 6'h03, 0, 0, 6'h03, 6'h02, 6'h00, 1, 6'h01, 6'h01, 1);
        add(1, 6'h03, 0, 1, 6'h03, 6'h00, 6'h00, 1, 6'h01, 6'h01, 0);
        // drop and clear on the same edge: set wins
        for (int k = 0; k < 3; k++)
            add(1, 6'h07, 0, 0, 6'h03, 6'h00, 6'h00, 1, 6'h01, 6'h01, 0);
        add(1, 6'h07, 0, 1, 6'h07, 6'h04, 6'h00, 1, 6'h01, 6'h01, 1);
        add(1, 6'h07, 0, 1, 6'h07, 6'h00, 6'h00, 1, 6'h01, 6'h01, 0);
        // transfer and bit-5 change on the same edge
        for (int k = 0; k < 3; k++)
            add(1, 6'h27, 0, 0, 6'h07, 6'h00, 6'h00, 1, 6'h01, 6'h01, 0);
        add(1, 6'h27, 1, 0, 6'h27, 6'h20, 6'h00, 1, 6'h27, 6'h20, 0);
        add(1, 6'h27, 1, 0, 6'h27, 6'h00, 6'h00, 0, 6'h27, 6'h20, 0);
        for (int k = 0; k < 3; k++)
            add(1, 6'h00, 1, 0, 6'h27, 6'h00, 6'h00, 0, 6'h27, 6'h20, 0);
        add(1, 6'h00, 1, 0, 6'h00, 6'h00, 6'h27, 1, 6'h00, 6'h27, 0);
        add(1, 6'h00, 1, 0, 6'h00, 6'h00, 6'h00, 0, 6'h00, 6'h27, 0);

        foreach (vecs[n]) begin
            edgeA(vecs[n].rstN, vecs[n].in, vecs[n].rdy, vecs[n].clr);
            chk($sformatf("v%0d outD", n), 32'(outA), 32'(vecs[n].expOut));
            chk($sformatf("v%0d rise", n), 32'(riseA), 32'(vecs[n].expRise));
            chk($sformatf("v%0d fall", n), 32'(fallA), 32'(vecs[n].expFall));
            chk($sformatf("v%0d evt_valid", n), 32'(evtA.evt_valid), 32'(vecs[n].expValid));
            chk($sformatf("v%0d evt_data", n), 32'(evtA.evt_data), 32'(vecs[n].expData));
            chk($sformatf("v%0d evt_mask", n), 32'(evtA.evt_mask), 32'(vecs[n].expMask));
            chk($sformatf("v%0d evt_overflow", n), 32'(evtA.evt_overflow), 32'(vecs[n].expOvf));
        end

        // mid-count reset: cnt[2] reaches 2, then reset, then hold bit 2 high
        edgeA(1, 6'h04, 0, 0);
        edgeA(1, 6'h04, 0, 0);
        chk("midcnt pre outD", 32'(outA), 32'h0);
        edgeA(0, 6'h04, 0, 0);
        chk("midcnt rst outD", 32'(outA), 32'h0);
        chk("midcnt rst mask", 32'(evtA.evt_mask), 32'h0);
        chk("midcnt rst valid", 32'(evtA.evt_valid), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            edgeA(1, 6'h04, 0, 0);
            chk($sformatf("midcnt e%0d outD", k), 32'(outA), 32'h0);
            chk($sformatf("midcnt e%0d rise", k), 32'(riseA), 32'h0);
        end
        edgeA(1, 6'h04, 0, 0);
        chk("midcnt e4 outD", 32'(outA), 32'h04);
        chk("midcnt e4 rise", 32'(riseA), 32'h04);
        chk("midcnt e4 valid", 32'(evtA.evt_valid), 32'h1);
        chk("midcnt e4 mask", 32'(evtA.evt_mask), 32'h04);

        // one-sample build: toggling bit 0 every cycle with the consumer ready
        for (int j = 0; j < 8; j++) begin
            logic b;
            b = (j % 2 == 0);
            inB = {5'b0, b};
            edgeA(1, 6'h04, 1, 0);
            chk($sformatf("s1 c%0d outD", j), 32'(outB), 32'(b));
            chk($sformatf("s1 c%0d rise", j), 32'(riseB), 32'(b));
            chk($sformatf("s1 c%0d fall", j), 32'(fallB), 32'(!b));
            chk($sformatf("s1 c%0d valid", j), 32'(evtB.evt_valid), 32'h1);
            chk($sformatf("s1 c%0d data", j), 32'(evtB.evt_data), 32'(b));
            chk($sformatf("s1 c%0d mask", j), 32'(evtB.evt_mask), 32'h1);
            chk($sformatf("s1 c%0d ovf", j), 32'(evtB.evt_overflow), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
